sipo_word_collector: RTL
========================

Name: sipo_word_collector

Overview:
- Downstream consumer of the 4-bit serial shift stage.
- Takes the LSB-first serial stream (`so`) plus a per-bit strobe and assembles WIDTH-bit words.
- Presents each completed word on a registered valid/ready output for the parallel datapath.
- Supports word realignment through `sync` and flags dropped words with a sticky overrun.

Parameters:
- WIDTH, 4, data word width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset.
- si  input  1  serial data bit, LSB of word first.
- si_valid  input  1  `si` sampled on this edge when 1.
- sync  input  1  discard partial word; next accepted bit is bit 0.
- word_out  output  WIDTH  assembled word, stable while `word_valid`=1.
- word_valid  output  1  `word_out` holds an unconsumed word.
- word_ready  input  1  consumer accepts the word when `word_valid` and `word_ready` are both 1.
- parity_err  output  1  parity mismatch for the current `word_out` (feature-dependent).
- overrun  output  1  sticky: a completed word was dropped.
- bit_cnt  output  CNT_W  number of data bits collected in the current partial word.

Behaviour:
- Reset (`clear`=1, asynchronous) forces:
  - shift register = 0, `bit_cnt` = 0, state = COLLECT;
  - `word_out` = 0, `word_valid` = 0, `parity_err` = 0, `overrun` = 0.
- Reset mid-word discards the partial word and any held output word.
- Shifting:
  - On an accepted bit: `shreg <= {si, shreg[WIDTH-1:1]}`, i.e. right shift with the new bit entering the MSB.
  - After WIDTH accepted bits, the first-received bit sits at bit 0.
- States:
  - COLLECT: count data bits. When `bit_cnt` = WIDTH-1 and `si_valid`=1, the word completes.
  - PARITY: present only when PARITY_EN is defined; see Optional Feature.
- Completion and output register:
  - Completing edge: the full word, including the current `si`, is offered to the output register.
  - `bit_cnt` returns to 0.
  - Latency: `word_valid` rises immediately after the edge that samples the last bit (0 cycles of added delay).
- Load rule at the completing edge:
  - If `word_valid`=0, or `word_valid`=1 and `word_ready`=1 (consumed this same edge), load `word_out` and keep/set `word_valid`=1.
  - Otherwise keep the old word and set `overrun`=1. The new word is lost.
- Handshake:
  - `word_valid` clears on the edge where `word_valid`=1 and `word_ready`=1, unless a new word loads on that same edge.
  - `word_out` does not change while `word_valid`=1 and `word_ready`=0.
  - Bit collection continues regardless of `word_ready` (no backpressure on the serial side).
- sync:
  - The partial word is discarded and `bit_cnt` = 0; the state returns to COLLECT.
  - If `si_valid`=1 on the same edge, that bit is taken as bit 0 of the new word (`bit_cnt` becomes 1).
  - `sync` never affects `word_out`/`word_valid`.
- `si_valid`=0: no state change, except the handshake.
- `overrun` clears only on `clear`.

Optional Feature:
- Macro: SIPO_WORD_COLLECTOR_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, the FSM enters PARITY instead of completing the word.
  - The next accepted bit is an even-parity bit. The word completes on that edge.
  - `parity_err` = XOR(data bits, parity bit), loaded together with `word_out` under the same load rule.
  - `sync` in PARITY returns to COLLECT and drops the word.
  - `bit_cnt` holds WIDTH while in PARITY.
- Undefined: no PARITY state; `parity_err` is tied to 0.

Decomposition:
- Shared package `sipo_pkg`:
  - state enum `{COLLECT, PARITY}`;
  - default WIDTH constant;
  - function `even_parity(word)`.
- One natural sub-module: `sipo_out_reg`, the output holding register with the valid/ready/overrun logic. The shift/count/FSM logic stays in the top level.

Test Plan:
- WIDTH=4, after `clear`:
  - Stimulus: `si` = 0,1,0,0 with `si_valid`=1 every edge and `word_ready`=1.
  - Response: `word_out`=4'b0010 and `word_valid`=1 right after the 4th edge; `word_valid`=0 after the next edge.
- Hold and overrun:
  - Stimulus: `word_ready`=0 while 1,1,1,1 and then 1,0,1,0 are sent.
  - Response: `word_out` stays 4'b1111 and `word_valid` stays 1; `overrun`=1 after the 8th bit.
  - Then `word_ready`=1: the word is consumed and `overrun` stays 1.
- Simultaneous consume and complete:
  - Stimulus: `word_ready`=1 on the edge the second word completes.
  - Response: `word_out` switches to the new word, `word_valid` stays 1, `overrun`=0.
- Sync realign:
  - Stimulus: bits 1,1, then `sync`=1 with `si`=1 and `si_valid`=1, then 0,0,1.
  - Response: `bit_cnt` 0→1→2→1→2→3→0; `word_out`=4'b1001.
- Async clear mid-word:
  - Stimulus: assert `clear` between edges after 2 bits.
  - Response: all outputs 0 immediately without a clock edge; the following 4 bits produce a clean word.
- With PARITY_EN:
  - Stimulus: data 1,0,1,1 then parity 1.
  - Response: `word_out`=4'b1101, `parity_err`=0.
  - Stimulus: same data with parity 0.
  - Response: `parity_err`=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel word collector.
// Holds the collector state encoding, the default word width and the
// even-parity helper used when SIPO_WORD_COLLECTOR_PARITY_EN is defined.
package sipo_pkg;

   localparam int SIPO_DEFAULT_WIDTH = 4;
   // Widest word the parity helper accepts; narrower words are zero-extended.
   localparam int SIPO_MAX_W         = 64;

   typedef enum logic {
      COLLECT = 1'b0,
      PARITY  = 1'b1
   } sipo_state_t;

   // Even parity: 1 when the word holds an odd number of ones.
   function automatic logic even_parity(input logic [SIPO_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register for the word collector.
// Loads a completed word when the slot is empty or being consumed on the
// same edge; otherwise drops the word and raises the sticky overrun flag.
module sipo_out_reg
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_par_err,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_word,
   output logic             o_valid,
   output logic             o_par_err,
   output logic             o_overrun
);

   logic [WIDTH-1:0] r_word;
   logic             r_valid;
   logic             r_par_err;
   logic             r_overrun;

   // Holding register with valid/ready handshake and sticky overrun.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_word    <= '0;
         r_valid   <= 1'b0;
         r_par_err <= 1'b0;
         r_overrun <= 1'b0;
      end else if (i_load) begin
         if (!r_valid || i_ready) begin
            r_word    <= i_word;
            r_par_err <= i_par_err;
            r_valid   <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_word    = r_word;
   assign o_valid   = r_valid;
   assign o_par_err = r_par_err;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_word_collector.sv
// Serial-to-parallel word collector.
// Assembles LSB-first serial bits into WIDTH-bit words and hands them to
// sipo_out_reg. Optional trailing even-parity bit enabled by the macro
// SIPO_WORD_COLLECTOR_PARITY_EN.
//
// state   | meaning
// COLLECT | shifting data bits, bit_cnt counts collected bits
// PARITY  | all data bits held, waiting for the parity bit (macro only)
module sipo_word_collector
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             si,
   input  logic             si_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             parity_err,
   output logic             overrun,
   output logic [CNT_W-1:0] bit_cnt
);

   sipo_state_t      r_state;
   sipo_state_t      w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_shifted;
   logic             w_complete;
   logic [WIDTH-1:0] w_word;
   logic             w_par_err;

   assign w_shifted = {si, r_shreg[WIDTH-1:1]};

   // State, shift register and bit counter.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state   <= COLLECT;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_cnt_nxt;
      end
   end

   // Next-state, shifting and word-completion decode.
   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_bit_cnt;
      w_complete  = 1'b0;
      w_word      = w_shifted;
      w_par_err   = 1'b0;
      if (sync) begin
         // Realign: a bit sampled with sync becomes bit 0 of the new word.
         w_state_nxt = COLLECT;
         if (si_valid) begin
            w_shreg_nxt = {si, {(WIDTH-1){1'b0}}};
            w_cnt_nxt   = CNT_W'(1);
         end else begin
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
         end
      end else if (si_valid) begin
`ifdef SIPO_WORD_COLLECTOR_PARITY_EN
         if (r_state == PARITY) begin
            w_complete  = 1'b1;
            w_word      = r_shreg;
            w_par_err   = even_parity({{(SIPO_MAX_W-WIDTH){1'b0}}, r_shreg}) ^ si;
            w_cnt_nxt   = '0;
            w_state_nxt = COLLECT;
         end else if (r_bit_cnt == CNT_W'(WIDTH-1)) begin
            w_shreg_nxt = w_shifted;
            w_cnt_nxt   = CNT_W'(WIDTH);
            w_state_nxt = PARITY;
         end else begin
            w_shreg_nxt = w_shifted;
            w_cnt_nxt   = r_bit_cnt + 1'b1;
         end
`else
         w_shreg_nxt = w_shifted;
         if (r_bit_cnt == CNT_W'(WIDTH-1)) begin
            w_complete = 1'b1;
            w_cnt_nxt  = '0;
         end else begin
            w_cnt_nxt  = r_bit_cnt + 1'b1;
         end
`endif
      end
   end

   sipo_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .clear     (clear),
      .i_load    (w_complete),
      .i_word    (w_word),
      .i_par_err (w_par_err),
      .i_ready   (word_ready),
      .o_word    (word_out),
      .o_valid   (word_valid),
      .o_par_err (parity_err),
      .o_overrun (overrun)
   );

   assign bit_cnt = r_bit_cnt;

endmodule
